// File: rtl/dcache_snoop_if.sv
// Signal bundle between one core's L1 data cache, the coherence controller and the snoop agent.
// The agent takes the slave view; the core/controller side takes the master view.
interface dcache_snoop_if;
    logic        l_wen;
    logic [31:0] l_addr;
    logic [31:0] l_data;
    logic [1:0]  l_state;
    logic        l_req;
    logic        l_rdx;
    logic        l_busy;
    logic        ccwait;
    logic        ccinv;
    logic [31:0] ccsnoopaddr;
    logic        cctrans;
    logic        ccwrite;
    logic [31:0] dstore;

    modport slave (
        input  l_wen, l_addr, l_data, l_state, l_req, l_rdx,
        input  ccwait, ccinv, ccsnoopaddr,
        output l_busy, cctrans, ccwrite, dstore
    );

    modport master (
        output l_wen, l_addr, l_data, l_state, l_req, l_rdx,
        output ccwait, ccinv, ccsnoopaddr,
        input  l_busy, cctrans, ccwrite, dstore
    );
endinterface

// File: rtl/dcache_snoop_agent.sv
// Responding end of the MSI bus protocol for one L1 data cache: per-frame tag/data/state,
// combinational snoop lookup and supply, and post-snoop invalidate/downgrade.
module dcache_snoop_agent #(
    parameter int SETS = 8
) (
    input  logic           CLK,
    input  logic           nRST,
    dcache_snoop_if.slave  bus_io
);
    localparam int IDX_W = $clog2(SETS);
    localparam int TAG_W = 29 - IDX_W;

    localparam logic [1:0] MSI_I = 2'd0;
    localparam logic [1:0] MSI_S = 2'd1;
    localparam logic [1:0] MSI_M = 2'd2;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_SNOOP,
        ST_UPDATE
    } fsm_t;

    fsm_t             fsm_q, fsm_d;
    logic [IDX_W-1:0] sidx_q, sidx_d;
    logic             hit_q, hit_d;
    logic             hitm_q, hitm_d;
    logic             inv_q, inv_d;
    logic             upd_en;

    logic [TAG_W-1:0] frame_tag   [SETS];
    logic [31:0]      frame_w0    [SETS];
    logic [31:0]      frame_w1    [SETS];
    logic [1:0]       frame_state [SETS];

    logic [IDX_W-1:0] snp_idx;
    logic [TAG_W-1:0] snp_tag;
    logic [IDX_W-1:0] loc_idx;
    logic             snp_hit;
    logic             snp_hitm;
    logic [31:0]      snp_word;
    logic             req_role;
    logic             snoop_act;
    logic             busy;
    logic             loc_we;
    logic             unused_ok;

    assign snp_idx  = bus_io.ccsnoopaddr[3 +: IDX_W];
    assign snp_tag  = bus_io.ccsnoopaddr[31 -: TAG_W];
    assign loc_idx  = bus_io.l_addr[3 +: IDX_W];
    assign snp_hit  = (frame_state[snp_idx] != MSI_I) && (frame_tag[snp_idx] == snp_tag);
    assign snp_hitm = snp_hit && (frame_state[snp_idx] == MSI_M);
    assign snp_word = bus_io.ccsnoopaddr[2] ? frame_w1[snp_idx] : frame_w0[snp_idx];

    // A same-block request from this core wins: we stay requester and never snoop ourselves.
    assign req_role  = bus_io.l_req && (bus_io.ccsnoopaddr[31:3] == bus_io.l_addr[31:3]);
    assign snoop_act = bus_io.ccwait && !req_role;
    assign busy      = snoop_act || (fsm_q != ST_IDLE);
    assign loc_we    = bus_io.l_wen && !busy;

    assign bus_io.l_busy  = nRST && busy;
    assign bus_io.cctrans = nRST && bus_io.l_req && !snoop_act;
    assign bus_io.ccwrite = nRST && (snoop_act ? snp_hitm : (bus_io.l_req && bus_io.l_rdx));
    assign bus_io.dstore  = (nRST && snoop_act && snp_hitm) ? snp_word : 32'd0;

    assign unused_ok = ^{bus_io.l_addr[1:0], bus_io.ccsnoopaddr[1:0]};

    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            fsm_q  <= ST_IDLE;
            sidx_q <= '0;
            hit_q  <= 1'b0;
            hitm_q <= 1'b0;
            inv_q  <= 1'b0;
        end else begin
            fsm_q  <= fsm_d;
            sidx_q <= sidx_d;
            hit_q  <= hit_d;
            hitm_q <= hitm_d;
            inv_q  <= inv_d;
        end
    end

    always_comb begin
        fsm_d  = fsm_q;
        sidx_d = sidx_q;
        hit_d  = hit_q;
        hitm_d = hitm_q;
        inv_d  = inv_q;
        upd_en = 1'b0;
        case (fsm_q)
            ST_IDLE: begin
                if (snoop_act) begin
                    fsm_d  = ST_SNOOP;
                    sidx_d = snp_idx;
                    hit_d  = snp_hit;
                    hitm_d = snp_hitm;
                    inv_d  = bus_io.ccinv;
                end
            end
            ST_SNOOP: begin
                if (bus_io.ccwait) begin
                    inv_d = inv_q || bus_io.ccinv;
                end else begin
                    fsm_d = ST_UPDATE;
                end
            end
            ST_UPDATE: begin
                upd_en = 1'b1;
                fsm_d  = ST_IDLE;
            end
            default: fsm_d = ST_IDLE;
        endcase
    end

    genvar gi;
    generate
        for (gi = 0; gi < SETS; gi++) begin : g_frame
            logic [1:0]       state_q, state_d;
            logic [TAG_W-1:0] tag_q;
            logic [31:0]      w0_q;
            logic [31:0]      w1_q;
            logic             sel_loc;
            logic             sel_upd;

            assign sel_loc = loc_we && (loc_idx == IDX_W'(gi));
            assign sel_upd = upd_en && hit_q && (sidx_q == IDX_W'(gi));

            // Snoop outcome: invalidate wins over downgrade; S stays S unless invalidated.
            always_comb begin
                state_d = state_q;
                if (sel_loc) begin
                    state_d = bus_io.l_state;
                end else if (sel_upd) begin
                    if (inv_q) begin
                        state_d = MSI_I;
                    end else if (hitm_q) begin
                        state_d = MSI_S;
                    end
                end
            end

            always_ff @(posedge CLK or negedge nRST) begin
                if (!nRST) begin
                    state_q <= MSI_I;
                end else begin
                    state_q <= state_d;
                end
            end

            always_ff @(posedge CLK) begin
                if (sel_loc) begin
                    tag_q <= bus_io.l_addr[31 -: TAG_W];
                    if (bus_io.l_addr[2]) begin
                        w1_q <= bus_io.l_data;
                    end else begin
                        w0_q <= bus_io.l_data;
                    end
                end
            end

            assign frame_state[gi] = state_q;
            assign frame_tag[gi]   = tag_q;
            assign frame_w0[gi]    = w0_q;
            assign frame_w1[gi]    = w1_q;
        end
    endgenerate
endmodule

// File: tb/tb_dcache_snoop_agent.sv
// Randomised scoreboard bench for dcache_snoop_agent: stimulus pushes predicted outputs,
// a negedge monitor pops and compares them against the DUT.
module tb_dcache_snoop_agent;
    logic CLK = 1'b0;
    logic nRST;

    dcache_snoop_if bus();

    dcache_snoop_agent #(.SETS(8)) dut (
        .CLK    (CLK),
        .nRST   (nRST),
        .bus_io (bus)
    );

    always #5 CLK = ~CLK;

    localparam int K_RST  = 0;
    localparam int K_WR   = 1;
    localparam int K_SNP  = 2;
    localparam int K_UPD  = 3;
    localparam int K_DONE = 4;
    localparam int K_REQ  = 5;

    // Reference model: plain MSI frames
    logic [25:0] m_tag  [8];
    logic [31:0] m_data [8][2];
    int          m_state[8];

    typedef struct {
        int          kind;
        int          txn;
        logic        ct;
        logic        cw;
        logic        bz;
        logic [31:0] ds;
        int          fidx;
        logic [1:0]  fst;
    } exp_t;

    exp_t exp_q[$];
    int   checks = 0;
    int   errors = 0;
    int   txn    = 0;

    function automatic string kname(input int k);
        case (k)
            K_RST:  return "reset";
            K_WR:   return "write";
            K_SNP:  return "snoop";
            K_UPD:  return "update";
            K_DONE: return "done";
            default: return "request";
        endcase
    endfunction

    function automatic exp_t predict(input int kind, input logic bz, input int fidx);
        exp_t        e;
        logic [31:0] sa;
        int          idx;
        logic        req_role, snp, hit, hm;
        sa       = bus.ccsnoopaddr;
        idx      = int'(sa[5:3]);
        req_role = bus.l_req && (sa[31:3] == bus.l_addr[31:3]);
        snp      = bus.ccwait && !req_role;
        hit      = (m_state[idx] != 0) && (m_tag[idx] == sa[31:6]);
        hm       = hit && (m_state[idx] == 2);
        e.kind   = kind;
        e.txn    = txn;
        e.fidx   = fidx;
        e.fst    = 2'd0;
        if (fidx >= 0) e.fst = 2'(m_state[fidx]);
        if (!nRST) begin
            e.ct = 1'b0; e.cw = 1'b0; e.bz = 1'b0; e.ds = 32'd0;
        end else begin
            e.bz = bz;
            e.ct = bus.l_req && !snp;
            e.cw = snp ? hm : (bus.l_req && bus.l_rdx);
            e.ds = (snp && hm) ? m_data[idx][sa[2]] : 32'd0;
        end
        return e;
    endfunction

    always @(negedge CLK) begin
        exp_t e;
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            checks++;
            if ({bus.cctrans, bus.ccwrite, bus.l_busy, bus.dstore} !== {e.ct, e.cw, e.bz, e.ds}) begin
                errors++;
                $display("FAIL %s txn=%0d: trans/write/busy/dstore got %b/%b/%b/%h want %b/%b/%b/%h",
                         kname(e.kind), e.txn, bus.cctrans, bus.ccwrite, bus.l_busy, bus.dstore,
                         e.ct, e.cw, e.bz, e.ds);
            end
            if (e.fidx >= 0) begin
                checks++;
                if (dut.frame_state[e.fidx] !== e.fst) begin
                    errors++;
                    $display("FAIL %s-state txn=%0d frame %0d: got %0d want %0d",
                             kname(e.kind), e.txn, e.fidx, dut.frame_state[e.fidx], e.fst);
                end
            end
        end
    end

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic push(input int kind, input logic bz, input int fidx);
        exp_q.push_back(predict(kind, bz, fidx));
    endtask

    function automatic logic [31:0] raddr();
        logic [25:0] t;
        t = 26'($urandom_range(0, 3));
        return {t, 3'($urandom_range(0, 7)), 1'($urandom_range(0, 1)), 2'b00};
    endfunction

    task automatic local_write(input logic [31:0] a, input logic [31:0] d, input logic [1:0] st);
        int idx;
        idx = int'(a[5:3]);
        bus.l_wen = 1'b1; bus.l_addr = a; bus.l_data = d; bus.l_state = st;
        push(K_WR, 1'b0, -1);
        tick();
        bus.l_wen = 1'b0;
        m_tag[idx] = a[31:6];
        m_data[idx][a[2]] = d;
        m_state[idx] = int'(st);
        push(K_WR, 1'b0, idx);
        tick();
        txn++;
        $display("txn %0d: write addr=%h data=%h state=%0d", txn, a, d, st);
    endtask

    task automatic fill(input logic [31:0] a, input logic [1:0] st);
        local_write({a[31:3], 3'b000}, $urandom, st);
        local_write({a[31:3], 3'b100}, $urandom, st);
    endtask

    task automatic snoop(input logic [31:0] a, input int len, input logic [31:0] inv_mask,
                         input logic walk, input logic lreq, input logic wen_first);
        int   idx;
        logic inv, hit, hm;
        idx = int'(a[5:3]);
        inv = 1'b0;
        hit = (m_state[idx] != 0) && (m_tag[idx] == a[31:6]);
        hm  = hit && (m_state[idx] == 2);
        bus.l_req  = lreq;
        bus.l_rdx  = 1'($urandom_range(0, 1));
        bus.l_addr = a ^ 32'h100;
        for (int c = 0; c < len; c++) begin
            bus.ccwait      = 1'b1;
            bus.ccsnoopaddr = {a[31:3], walk ? c[0] : 1'($urandom_range(0, 1)), 2'b00};
            bus.ccinv       = inv_mask[c];
            inv             = inv | inv_mask[c];
            if (c == 0 && wen_first) begin
                bus.l_wen = 1'b1; bus.l_data = $urandom; bus.l_state = 2'd2;
            end
            push(K_SNP, 1'b1, -1);
            tick();
            bus.l_wen = 1'b0;
        end
        bus.ccwait = 1'b0;
        bus.ccinv  = 1'b0;
        push(K_SNP, 1'b1, -1);
        tick();
        push(K_UPD, 1'b1, -1);
        tick();
        if (hit) m_state[idx] = inv ? 0 : (hm ? 1 : m_state[idx]);
        bus.l_req = 1'b0;
        push(K_DONE, 1'b0, idx);
        tick();
        txn++;
        $display("txn %0d: snoop addr=%h len=%0d hit=%b dirty=%b inv=%b lreq=%b wen=%b",
                 txn, a, len, hit, hm, inv, lreq, wen_first);
    endtask

    task automatic requester(input logic [31:0] a, input logic rdx, input int len);
        bus.l_req = 1'b1; bus.l_rdx = rdx; bus.l_addr = a; bus.ccwait = 1'b0;
        push(K_REQ, 1'b0, -1);
        tick();
        for (int c = 0; c < len; c++) begin
            bus.ccwait      = 1'b1;
            bus.ccsnoopaddr = {a[31:3], 1'($urandom_range(0, 1)), 2'b00};
            bus.ccinv       = 1'($urandom_range(0, 1));
            push(K_REQ, 1'b0, -1);
            tick();
        end
        bus.ccwait = 1'b0;
        bus.ccinv  = 1'b0;
        push(K_REQ, 1'b0, int'(a[5:3]));
        tick();
        bus.l_req = 1'b0;
        txn++;
        $display("txn %0d: request addr=%h rdx=%b len=%0d", txn, a, rdx, len);
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish within time budget");
        $fatal(1, "watchdog");
    end

    initial begin
        bus.l_wen = 1'b0; bus.l_addr = '0; bus.l_data = '0; bus.l_state = 2'd0;
        bus.l_req = 1'b0; bus.l_rdx = 1'b0;
        bus.ccwait = 1'b0; bus.ccinv = 1'b0; bus.ccsnoopaddr = '0;
        for (int i = 0; i < 8; i++) begin
            m_state[i] = 0; m_tag[i] = '0; m_data[i][0] = '0; m_data[i][1] = '0;
        end
        nRST = 1'b0;
        tick();
        bus.ccwait = 1'b1; bus.ccsnoopaddr = raddr();
        push(K_RST, 1'b0, -1);
        tick();
        bus.ccwait = 1'b0;
        nRST = 1'b1;
        push(K_RST, 1'b0, 0);
        tick();
        snoop(raddr(), 2, 32'h0, 1'b0, 1'b0, 1'b0);

        // Dirty supply of both words, then downgrade to S
        local_write(32'h50, 32'hAAAA0000, 2'd2);
        local_write(32'h54, 32'hBBBB1111, 2'd2);
        snoop(32'h50, 2, 32'h0, 1'b1, 1'b0, 1'b0);

        // Invalidate mid-window, then a follow-up snoop must miss
        local_write(32'h50, 32'hAAAA0000, 2'd2);
        snoop(32'h50, 3, 32'h2, 1'b1, 1'b0, 1'b0);
        snoop(32'h50, 1, 32'h0, 1'b1, 1'b0, 1'b0);

        // Shared frame: BusRdX invalidates; tag mismatch leaves it alone
        local_write(32'h50, 32'hAAAA0000, 2'd1);
        snoop(32'h50, 2, 32'h1, 1'b1, 1'b0, 1'b0);
        local_write(32'h50, 32'hAAAA0000, 2'd1);
        snoop(32'h150, 2, 32'h3, 1'b1, 1'b0, 1'b0);

        requester(32'h80, 1'b1, 2);
        requester(32'h88, 1'b0, 1);

        // Write dropped when coinciding with the snoop window opening
        snoop(32'h50, 2, 32'h0, 1'b0, 1'b0, 1'b1);

        // Asynchronous reset in the middle of a dirty snoop
        local_write(32'h50, 32'hCAFE0000, 2'd2);
        bus.ccwait = 1'b1; bus.ccsnoopaddr = 32'h50;
        push(K_RST, 1'b1, -1);
        tick();
        push(K_RST, 1'b1, -1);
        tick();
        nRST = 1'b0;
        for (int i = 0; i < 8; i++) m_state[i] = 0;
        push(K_RST, 1'b0, 2);
        tick();
        bus.ccwait = 1'b0;
        nRST = 1'b1;
        push(K_RST, 1'b0, 2);
        tick();
        txn++;
        $display("txn %0d: reset during snoop", txn);

        for (int n = 0; n < 300; n++) begin
            int op;
            op = $urandom_range(0, 9);
            if (op < 4) begin
                fill(raddr(), 2'($urandom_range(0, 2)));
            end else if (op < 8) begin
                snoop(raddr(), $urandom_range(1, 4), $urandom & $urandom,
                      1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                      ($urandom_range(0, 7) == 0));
            end else begin
                requester(raddr(), 1'($urandom_range(0, 1)), $urandom_range(0, 3));
            end
        end

        tick();
        tick();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/dcache_snoop_agent.md
# dcache_snoop_agent

Cache-side coherence agent for one core's L1 data cache: the responding end of the bus coherence protocol driven by the shared coherence controller. It owns the per-frame MSI state and data copy used for snoops, and answers snoop lookups with `ccwrite` (dirty-hit / supply). It supplies cache-to-cache data on `dstore` and applies invalidations and downgrades when a snoop completes. It also presents the core's own miss requests to the bus as `cctrans`/`ccwrite`.

## Interface
- `SETS`, 8: direct-mapped frames; index = `addr[5:3]`, word = `addr[2]`, tag = `addr[31:6]`.
- `CLK` in 1: clock.
- `nRST` in 1: reset, asynchronous, active-low.
- `l_wen` in 1: local frame write (fill or store update).
- `l_addr` in 32: local address (write target and pending-request address).
- `l_data` in 32: word written at `l_addr[2]`.
- `l_state` in 2: MSI state written with `l_wen` (0=I, 1=S, 2=M).
- `l_req` in 1: core has a miss/upgrade pending for `l_addr`.
- `l_rdx` in 1: pending request is BusRdX (write intent); else BusRd.
- `l_busy` out 1: snoop in progress; core must hold `l_wen` and the request fields.
- `ccwait` in 1: bus in coherence phase (snoop window).
- `ccinv` in 1: invalidate request for the snooped block.
- `ccsnoopaddr` in 32: snooped address; also tracks requester's word during transfer.
- `cctrans` out 1: bus transaction request.
- `ccwrite` out 1: requester role = write intent; snooper role = dirty hit, will supply.
- `dstore` out 32: snoop supply data.

## Operation
- Storage: per frame a valid tag (26 b), 2 data words, and a 2-bit MSI state. All frames reset to I; data is don't-care.
- Role: the agent is requester when `l_req` is high and `ccsnoopaddr[31:3] == l_addr[31:3]`; otherwise it is snooper whenever `ccwait` is high.
- Same-block concurrent requests from both cores resolve to the requester role. No supply or invalidation occurs, and the controller serves the transaction from RAM.
- Snoop lookup (combinational on `ccsnoopaddr`): hit = state != I and tag match. `hitM` = hit and state == M.
- Outputs:
  - `cctrans` = `l_req` and not snooper-active.
  - `ccwrite` = snooper-active ? `hitM` : (`l_req` & `l_rdx`).
  - `dstore` = frame word `ccsnoopaddr[2]` when snooper-active and `hitM`, else 0.
- FSM states:
  - IDLE → SNOOP when `ccwait` is high and the agent is snooper. On entry it latches index, hit, `hitM`.
  - SNOOP: `l_busy` = 1. Each cycle it ORs `ccinv` into a sticky `inv` flag. It stays while `ccwait` is high, and on `ccwait` low it moves to UPDATE.
  - UPDATE (1 cycle): if the latched hit is set, the frame goes to I when `inv` is set, else to S if it was M, else unchanged. Then → IDLE.
  - Requester role does not leave IDLE.
- Local writes in IDLE with `l_busy` = 0 update tag, word and state in the next cycle. A write in the same cycle as a `ccwait` rising edge is dropped, because `l_busy` goes high combinationally from `ccwait`.
- `l_busy` = (`ccwait` and snooper) or state != IDLE.

## Timing
- Reset values: all outputs 0, FSM IDLE, all frames I.
- `ccwrite` and `dstore` are combinational from `ccsnoopaddr`. They are valid in the first cycle of `ccwait`, so the controller samples the dirty hit in its snoop cycle.
- Supply: `dstore` follows `ccsnoopaddr[2]` the same cycle, so a 2-word block transfer needs no agent handshake.
- The state update commits one cycle after `ccwait` falls; `l_busy` drops the cycle after UPDATE.
- `ccinv` pulsed on any cycle of the window counts; repeated assertion is idempotent.
- Async reset mid-snoop returns the FSM to IDLE and all frames to I immediately; `ccwrite` returns to 0.
- A miss on snoop changes nothing, but the agent still walks SNOOP → UPDATE → IDLE.

## Test plan
- Reset then snoop any address with `ccwait`=1: `ccwrite`=0, `dstore`=0, no state change. After reset release: `cctrans`=0.
- Fill frame 2 with tag of 0x40 in M, data {0xAAAA0000, 0xBBBB1111}. Snoop 0x50 (word 0) then 0x54 (word 1) with `ccinv`=0: `ccwrite`=1 in the first cycle, `dstore` = 0xAAAA0000 then 0xBBBB1111. After `ccwait` falls, frame 2 is S.
- Same M fill, snoop 0x50 with `ccinv`=1 for one cycle mid-window: frame becomes I. A later snoop gives `ccwrite`=0.
- Frame in S, BusRdX snoop (`ccinv`=1): `ccwrite`=0, `dstore`=0, frame becomes I. Tag-mismatch snoop on the same index: frame unchanged.
- `l_req`=1, `l_rdx`=1, `l_addr`=0x80 with no `ccwait`: `cctrans`=1, `ccwrite`=1. `ccwait`=1 with `ccsnoopaddr`=0x84: requester role, `l_busy`=0, outputs unchanged.
- `nRST` asserted during SNOOP on an M hit: outputs 0 and frame I the same cycle. `l_wen` on a `ccwait` rising edge is ignored.
